// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame checker and its
// parity helper: parity mode encodings, FSM state type, frame config record
// and legal data-width bounds.
package uart_rx_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  // Bit counter must be able to hold DATA_WIDTH_MAX.
  localparam int BIT_CNT_W = $clog2(DATA_WIDTH_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } rx_state_e;

  // Line configuration captured at frame start and held for the whole frame.
  typedef struct packed {
    logic       par_en;
    logic [1:0] par_mode;
    logic       stop2;
  } frame_cfg_t;

endpackage

// File: rtl/uart_par_calc.sv
// Combinational expected-parity bit from the running data parity and the
// parity mode. Shared between the RX checker and the TX parity generator.
module uart_par_calc
  import uart_rx_pkg::*;
(
  input  logic       run_par_i,
  input  logic [1:0] par_mode_i,
  output logic       exp_par_o
);

  // Select the expected parity bit for the current mode.
  always_comb begin
    exp_par_o = run_par_i;
    case (par_mode_i)
      PAR_EVEN:  exp_par_o = run_par_i;
      PAR_ODD:   exp_par_o = ~run_par_i;
      PAR_MARK:  exp_par_o = 1'b1;
      PAR_SPACE: exp_par_o = 1'b0;
      default:   exp_par_o = run_par_i;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: assembles DATA_WIDTH data bits LSB-first from
// sampler strobes, checks parity (even/odd/mark/space) and one or two stop
// bits, and issues a registered one-cycle result per completed frame.
// Optional feature macro: PAR_ERR_CNT_EN adds saturating parity/stop error
// counters with a synchronous clear.
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sampled_bit,
  input  logic                  bit_valid,
  input  logic                  frame_start,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  STOP2,
  input  logic                  clr_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
`ifdef PAR_ERR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
`endif
);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_width_check
    $error("uart_rx_frame_checker: DATA_WIDTH must be within 5..9");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  frame_cfg_t            cfg_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  run_par_q;
  logic                  par_flag_q;
  logic                  stp_flag_q;
  logic                  exp_par;

  logic                  frame_done;
  logic                  frame_par_err;
  logic                  frame_stp_err;

  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  uart_par_calc u_par_calc (
    .run_par_i  (run_par_q),
    .par_mode_i (cfg_q.par_mode),
    .exp_par_o  (exp_par)
  );

  // FSM state register.
  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state: frame_start from any state (re)starts a frame.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_DATA;
    end else if (bit_valid) begin
      case (state_q)
        ST_DATA:   if (bit_cnt_q == LAST_BIT) state_d = cfg_q.par_en ? ST_PARITY : ST_STOP1;
        ST_PARITY: state_d = ST_STOP1;
        ST_STOP1:  state_d = cfg_q.stop2 ? ST_STOP2 : ST_IDLE;
        ST_STOP2:  state_d = ST_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  // FSM outputs: detect the final stop strobe and form the frame's flags,
  // folding in the stop bit being received this cycle.
  always_comb begin
    frame_done = 1'b0;
    if (bit_valid && !frame_start) begin
      case (state_q)
        ST_STOP1: frame_done = ~cfg_q.stop2;
        ST_STOP2: frame_done = 1'b1;
        default:  frame_done = 1'b0;
      endcase
    end
    frame_par_err = cfg_q.par_en & par_flag_q;
    frame_stp_err = stp_flag_q | ~sampled_bit;
  end

  // Frame datapath: config capture, shift register, bit counter, running
  // parity and the sticky parity/stop flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cfg_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      run_par_q  <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
    end else if (frame_start) begin
      cfg_q      <= '{par_en: PAR_EN, par_mode: PAR_MODE, stop2: STOP2};
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      run_par_q  <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        ST_DATA: begin
          shift_q   <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          run_par_q <= run_par_q ^ sampled_bit;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        ST_PARITY: par_flag_q <= (sampled_bit != exp_par);
        ST_STOP1, ST_STOP2: if (!sampled_bit) stp_flag_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Result registers: loaded once per completed frame, held until the next.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= frame_done;
      if (frame_done) begin
        p_data_q  <= shift_q;
        par_err_q <= frame_par_err;
        stp_err_q <= frame_stp_err;
      end
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef PAR_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] par_cnt_q, stp_cnt_q;
  logic                 par_inc, stp_inc;

  assign par_inc = frame_done & frame_par_err;
  assign stp_inc = frame_done & frame_stp_err;

  // Saturating count step; a clear coinciding with an increment leaves 1.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic inc, input logic clr);
    if (clr)                 return inc ? CNT_WIDTH'(1) : '0;
    if (inc && (cur != '1))  return cur + 1'b1;
    return cur;
  endfunction

  // Error counters, updated in the same cycle the flags are reported.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      par_cnt_q <= cnt_next(par_cnt_q, par_inc, clr_cnt);
      stp_cnt_q <= cnt_next(stp_cnt_q, stp_inc, clr_cnt);
    end
  end

  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;
`else
  // Without counters clr_cnt and CNT_WIDTH have no function.
  logic                 unused_clr_cnt;
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_clr_cnt   = clr_cnt;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Self-checking bench for uart_rx_frame_checker: directed frames from the
// feature list followed by randomized back-to-back frames, all compared
// against a frame-level reference model. Counter checks apply when the
// design is built with PAR_ERR_CNT_EN.
module tb_uart_rx_frame_checker;

  localparam int DW      = 8;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          sampled_bit = 1'b0;
  logic          bit_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          PAR_EN = 1'b0;
  logic [1:0]    PAR_MODE = 2'b00;
  logic          STOP2 = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;
`ifdef PAR_ERR_CNT_EN
  logic [CW-1:0] par_err_cnt;
  logic [CW-1:0] stp_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int dv_count = 0;
  int par_cnt_m = 0;
  int stp_cnt_m = 0;

  uart_rx_frame_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .sampled_bit (sampled_bit),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .PAR_EN      (PAR_EN),
    .PAR_MODE    (PAR_MODE),
    .STOP2       (STOP2),
    .clr_cnt     (clr_cnt),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy)
`ifdef PAR_ERR_CNT_EN
    ,
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Count result pulses away from the active edge.
  always @(negedge CLK) if (data_valid === 1'b1) dv_count++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef PAR_ERR_CNT_EN
    check({tag, " par_err_cnt"}, 32'(par_err_cnt), 32'(par_cnt_m));
    check({tag, " stp_err_cnt"}, 32'(stp_err_cnt), 32'(stp_cnt_m));
`endif
  endtask

  // Expected parity bit from the data word's population count.
  function automatic logic model_par_bit(input logic [DW-1:0] d, input logic [1:0] mode);
    int ones;
    ones = $countones(d);
    case (mode)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_cnt(input int cur, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc && cur < CNT_MAX) return cur + 1;
    return cur;
  endfunction

  // Drive one complete frame and check its result against the model.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic [1:0] pm,
                            input logic pb, input logic s2, input logic sa, input logic sb,
                            input bit gaps, input bit collide, input bit clr_end,
                            input string tag);
    logic bits[$];
    int   dv0;
    bit   exp_pe, exp_se;

    frame_start = 1'b1;
    PAR_EN      = pe;
    PAR_MODE    = pm;
    STOP2       = s2;
    bit_valid   = collide;
    sampled_bit = 1'b1;
    clr_cnt     = 1'b0;
    tick();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    dv0 = dv_count;

    // Configuration changes after frame start must be ignored.
    PAR_EN   = 1'($urandom);
    PAR_MODE = 2'($urandom);
    STOP2    = 1'($urandom);

    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(sa);
    if (s2) bits.push_back(sb);

    for (int k = 0; k < bits.size(); k++) begin
      bit_valid   = 1'b1;
      sampled_bit = bits[k];
      if (k == bits.size() - 1) clr_cnt = clr_end;
      tick();
      bit_valid   = 1'b0;
      clr_cnt     = 1'b0;
      sampled_bit = 1'($urandom);
      if (gaps && k != bits.size() - 1) repeat ($urandom_range(0, 2)) tick();
    end

    exp_pe = pe && (pb != model_par_bit(d, pm));
    exp_se = !sa || (s2 && !sb);
    par_cnt_m = model_cnt(par_cnt_m, exp_pe, clr_end);
    stp_cnt_m = model_cnt(stp_cnt_m, exp_se, clr_end);

    check({tag, " no_early_dv"}, 32'(dv_count), 32'(dv0));
    check({tag, " data_valid"}, 32'(data_valid), 32'd1);
    check({tag, " P_DATA"}, 32'(P_DATA), 32'(d));
    check({tag, " par_err"}, 32'(par_err), 32'(exp_pe));
    check({tag, " stp_err"}, 32'(stp_err), 32'(exp_se));
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
    check_counters(tag);
  endtask

  initial begin
    int dv_before;
    logic [DW-1:0] last_data;

    // Reset state.
    RST = 1'b0;
    repeat (3) tick();
    check("reset P_DATA", 32'(P_DATA), 32'd0);
    check("reset data_valid", 32'(data_valid), 32'd0);
    check("reset par_err", 32'(par_err), 32'd0);
    check("reset stp_err", 32'(stp_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check_counters("reset");
    RST = 1'b1;
    tick();

    // Strobes while idle are ignored.
    for (int i = 0; i < 4; i++) begin
      bit_valid   = 1'b1;
      sampled_bit = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    tick();
    check("idle busy", 32'(busy), 32'd0);
    check("idle no_dv", 32'(dv_count), 32'd0);

    // Directed frames.
    send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "even_a5");
    tick();
    check("hold data_valid", 32'(data_valid), 32'd0);
    check("hold P_DATA", 32'(P_DATA), 32'hA5);
    send_frame(8'h01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "odd_01");
    send_frame(8'h6E, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mark_p0");
    send_frame(8'h6E, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "space_p0");
    send_frame(8'hFF, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "nopar_ff");
    send_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "stop2_3c");
    send_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "stop1_3c");

    // Abort after three data bits; restart collides with a strobe.
    frame_start = 1'b1;
    PAR_EN = 1'b1; PAR_MODE = 2'b00; STOP2 = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    dv_before = dv_count;
    send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "abort_5a");
    tick();
    check("abort single_dv", 32'(dv_count), 32'(dv_before + 1));

    // Parity errors up to and past counter saturation.
    for (int i = 0; i < 5; i++)
      send_frame(8'(i * 37 + 3), 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sat");
    check("sat model", 32'(par_cnt_m), 32'(CNT_MAX));
    check_counters("saturated");
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    par_cnt_m = 0;
    stp_cnt_m = 0;
    check_counters("cleared");
    send_frame(8'h81, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "clr_inc");

    // Randomized back-to-back frames.
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 1'b1, 1'($urandom), ($urandom_range(0, 7) == 0), "rand");
    end
    last_data = P_DATA;
    tick();

    // Reset mid-frame.
    frame_start = 1'b1;
    PAR_EN = 1'b1; PAR_MODE = 2'b01; STOP2 = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    RST = 1'b0;
    tick();
    par_cnt_m = 0;
    stp_cnt_m = 0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst data_valid", 32'(data_valid), 32'd0);
    check("midrst P_DATA", 32'(P_DATA), 32'd0);
    check_counters("midrst");
    RST = 1'b1;
    dv_before = dv_count;
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    repeat (2) tick();
    check("midrst no_dv", 32'(dv_count), 32'(dv_before));
    check("midrst busy_after", 32'(busy), 32'd0);
    check("midrst P_DATA_after", 32'(P_DATA), 32'd0);
    if (last_data == 8'h00) check("midrst last_data_seen", 32'(dv_before), 32'(dv_count));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
# uart_rx_frame_checker

Sequential frame checker for the UART receive path, sitting between the data sampler and the RX register interface. It takes one sampled bit per strobe after a confirmed start bit and assembles a data word LSB-first. It computes parity incrementally and checks parity in even, odd, mark or space mode, plus one or two stop bits. Each frame ends with a one-cycle result pulse carrying the data and error flags; optional saturating counters track parity and stop errors.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- CNT_WIDTH, 8: width of each error counter.

- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset.
- sampled_bit  input  1  current sampled line value; qualified by bit_valid.
- bit_valid  input  1  one-cycle strobe, one per received bit after the start bit.
- frame_start  input  1  one-cycle strobe when the start bit is confirmed.
- PAR_EN  input  1  parity bit present in the frame.
- PAR_MODE  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
- STOP2  input  1  two stop bits expected.
- clr_cnt  input  1  synchronous clear of the error counters.
- P_DATA  output  DATA_WIDTH  received word; valid with data_valid and held until the next frame result.
- data_valid  output  1  one-cycle pulse per completed frame.
- par_err  output  1  parity mismatch for the reported frame.
- stp_err  output  1  stop-bit error for the reported frame.
- busy  output  1  frame reception in progress.
- par_err_cnt  output  CNT_WIDTH  saturating parity-error count (PAR_ERR_CNT_EN only).
- stp_err_cnt  output  CNT_WIDTH  saturating stop-error count (PAR_ERR_CNT_EN only).

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE → DATA on frame_start.
  - On that transition, PAR_EN, PAR_MODE and STOP2 are latched into a frame-config register.
  - The shift register, bit counter and running parity are cleared.
- DATA:
  - Each bit_valid shifts sampled_bit in at the MSB, which gives LSB-first assembly.
  - The running parity is XORed with sampled_bit and the counter increments.
  - After DATA_WIDTH bits: → PARITY if the latched PAR_EN is set, else → STOP1.
- PARITY: on bit_valid, compare against the expected parity bit, then → STOP1.
  - Even: expected = running parity.
  - Odd: expected = inverted running parity.
  - Mark: expected = 1.
  - Space: expected = 0.
  - A mismatch sets an internal par flag.
- STOP1: on bit_valid, sampled_bit = 0 sets an internal stop flag.
  - → STOP2 if the latched STOP2 is set.
  - Otherwise → IDLE, and the frame result is issued.
- STOP2: on bit_valid, sampled_bit = 0 sets the stop flag; → IDLE and the frame result is issued.
- Frame result: P_DATA, par_err and stp_err are loaded from the internal word and flags, and data_valid pulses.
- With PAR_EN = 0, par_err is always 0.
- bit_valid in IDLE is ignored.
- frame_start in any non-IDLE state aborts the current frame and restarts at DATA with fresh config. No result is issued for the aborted frame.
- frame_start and bit_valid in the same cycle: frame_start wins and that bit is discarded.
- Mid-frame changes to the configuration inputs have no effect until the next frame_start.
- Reset mid-frame: the FSM returns to IDLE and all outputs and counters are zeroed. No result is issued.

## Timing
- Reset values: P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, busy = 0, both counters = 0.
- busy rises the cycle after frame_start. It falls in the same cycle data_valid is high.
- Latency: data_valid, P_DATA and the flags are all registered. They appear one cycle after the bit_valid of the final stop bit.
- Results are stable from the data_valid cycle until the next result.
- Minimum bit_valid spacing is 1 cycle; back-to-back strobes are legal.
- A new frame_start is accepted in the same cycle data_valid is high.

## Configuration
- PAR_ERR_CNT_EN defined:
  - par_err_cnt and stp_err_cnt exist.
  - Each increments by 1 in the cycle its flag is reported with data_valid.
  - Both saturate at all-ones.
  - clr_cnt zeroes both.
  - clr_cnt in the same cycle as an increment loads 1.
- PAR_ERR_CNT_EN undefined: the counter ports and all counter logic are absent, and clr_cnt is ignored.

## Structure
- Package uart_rx_pkg holds:
  - parity mode constants PAR_EVEN/PAR_ODD/PAR_MARK/PAR_SPACE (2-bit);
  - the FSM state typedef;
  - DATA_WIDTH bounds.
- One sub-module, uart_par_calc: a combinational parity expectation taking running parity and PAR_MODE and returning the expected bit.
  - It is shared with the TX parity generator.
- FSM, shift register, counters and result registers live in the top module.

## Test plan
- Even parity, frame 0xA5, parity bit 0, stop 1 → data_valid one cycle after the stop strobe, P_DATA = 0xA5, par_err = 0, stp_err = 0.
- Odd parity, frame 0x01, parity bit 1 (expected 0), stop 1 → par_err = 1, stp_err = 0, par_err_cnt = 1.
- Mark mode with parity bit 0 → par_err = 1. Space mode with parity bit 0 → par_err = 0. PAR_EN = 0, frame 0xFF, stop 1 → par_err = 0 and P_DATA = 0xFF after 9 strobes.
- STOP2 = 1, frame 0x3C, first stop 1, second stop 0 → stp_err = 1, stp_err_cnt = 1. The same frame with STOP2 = 0 reports after the first stop.
- frame_start after 3 data bits, then a full 0x5A frame → exactly one data_valid, with P_DATA = 0x5A.
- CNT_WIDTH = 2, five parity-error frames → par_err_cnt = 3 (saturated). Then clr_cnt → 0. Then RST low mid-frame → busy = 0 and no data_valid.
